// File: rtl/core_io_pkg.sv
// Shared definitions for the core I/O AXI4-Lite engine: FSM states,
// default peripheral register map and AXI response codes.
package core_io_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TX_STAT_AR,
        ST_TX_STAT_R,
        ST_TX_AW,
        ST_TX_B,
        ST_RX_STAT_AR,
        ST_RX_STAT_R,
        ST_RX_AR,
        ST_RX_R
    } io_state_t;

    localparam logic [3:0] DEF_RX_ADDR   = 4'h0;
    localparam logic [3:0] DEF_TX_ADDR   = 4'h4;
    localparam logic [3:0] DEF_STAT_ADDR = 4'h8;

    localparam int DEF_RXV_BIT = 0;
    localparam int DEF_TXF_BIT = 3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int ERR_R_IDX = 0;
    localparam int ERR_B_IDX = 1;

endpackage

// File: rtl/core_io_fifo.sv
// Synchronous FIFO for posted TX bytes; pointers carry an extra wrap bit
// so full and empty are told apart without a separate count.
module core_io_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] head_reg;
    logic [IDX_W:0]    wr_ptr_reg;
    logic [IDX_W:0]    rd_ptr_reg;
    logic              push_en;
    logic              pop_en;

    assign full  = (wr_ptr_reg[IDX_W-1:0] == rd_ptr_reg[IDX_W-1:0]) &&
                   (wr_ptr_reg[IDX_W] != rd_ptr_reg[IDX_W]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);

    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    // Registered read of the head: the engine only consumes it several
    // cycles after the FIFO turns non-empty or after a pop, so it has settled.
    always_ff @(posedge CLK) begin
        if (push_en) begin
            mem[wr_ptr_reg[IDX_W-1:0]] <= push_data;
        end
        head_reg <= mem[rd_ptr_reg[IDX_W-1:0]];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    assign head = head_reg;

endmodule

// File: rtl/core_io_axil.sv
// AXI4-Lite master serving the core's in/out instructions against a UART-Lite
// style peripheral: posted TX through a FIFO, blocking RX via status polling.
module core_io_axil
    import core_io_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 4,
    parameter int                TX_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RX_ADDR   = ADDR_W'(DEF_RX_ADDR),
    parameter logic [ADDR_W-1:0] TX_ADDR   = ADDR_W'(DEF_TX_ADDR),
    parameter logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(DEF_STAT_ADDR),
    parameter int                RXV_BIT   = DEF_RXV_BIT,
    parameter int                TXF_BIT   = DEF_TXF_BIT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              OUT_VALID,
    input  logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_READY,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic              IN_DONE,
    output logic [DATA_W-1:0] IN_DATA,
    output logic              TX_EMPTY,
    output logic [1:0]        ERR,
    input  logic              ERR_CLR,
    output logic [ADDR_W-1:0] ARADDR,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [31:0]       RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RVALID,
    output logic              RREADY,
    output logic [ADDR_W-1:0] AWADDR,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [31:0]       WDATA,
    output logic [3:0]        WSTRB,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY
);

    io_state_t         state_reg, state_next;
    logic              pending_reg;
    logic              aw_done_reg;
    logic              w_done_reg;
    logic              in_done_reg;
    logic [DATA_W-1:0] in_data_reg;
    logic [1:0]        err_reg;
    logic [1:0]        err_set;

    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [DATA_W-1:0] fifo_head;

    logic              ar_fire, r_fire, aw_fire, w_fire, b_fire, rx_data_fire;
    logic [1:0]        resp_fire;
    logic [1:0]        resp_val [2];
    logic              unused_rdata;

    assign unused_rdata = ^RDATA;

    // Handshakes are decoded from state rather than from the VALID outputs,
    // which keeps the output process free of combinational feedback.
    assign ar_fire = ARREADY && (state_reg inside {ST_TX_STAT_AR, ST_RX_STAT_AR, ST_RX_AR});
    assign r_fire  = RVALID && (state_reg inside {ST_TX_STAT_R, ST_RX_STAT_R, ST_RX_R});
    assign aw_fire = (state_reg == ST_TX_AW) && !aw_done_reg && AWREADY;
    assign w_fire  = (state_reg == ST_TX_AW) && !w_done_reg && WREADY;
    assign b_fire  = (state_reg == ST_TX_B) && BVALID;
    assign rx_data_fire = (state_reg == ST_RX_R) && RVALID;

    assign fifo_push = OUT_VALID && OUT_READY;
    assign fifo_pop  = b_fire;

    core_io_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (TX_DEPTH)
    ) u_tx_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (fifo_push),
        .push_data (OUT_DATA),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_next = state_reg;
        ARVALID    = 1'b0;
        ARADDR     = '0;
        RREADY     = 1'b0;
        AWVALID    = 1'b0;
        AWADDR     = '0;
        WVALID     = 1'b0;
        WDATA      = '0;
        WSTRB      = '0;
        BREADY     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // TX first: an in is only serviced once every earlier out has drained.
                if (!fifo_empty) begin
                    state_next = ST_TX_STAT_AR;
                end else if (pending_reg) begin
                    state_next = ST_RX_STAT_AR;
                end
            end
            ST_TX_STAT_AR: begin
                ARVALID = 1'b1;
                ARADDR  = STAT_ADDR;
                if (ar_fire) state_next = ST_TX_STAT_R;
            end
            ST_TX_STAT_R: begin
                RREADY = 1'b1;
                if (r_fire) state_next = RDATA[TXF_BIT] ? ST_TX_STAT_AR : ST_TX_AW;
            end
            ST_TX_AW: begin
                AWVALID = !aw_done_reg;
                AWADDR  = TX_ADDR;
                WVALID  = !w_done_reg;
                WDATA   = 32'(fifo_head);
                WSTRB   = 4'b0001;
                if ((aw_done_reg || aw_fire) && (w_done_reg || w_fire)) begin
                    state_next = ST_TX_B;
                end
            end
            ST_TX_B: begin
                BREADY = 1'b1;
                if (b_fire) state_next = ST_IDLE;
            end
            ST_RX_STAT_AR: begin
                ARVALID = 1'b1;
                ARADDR  = STAT_ADDR;
                if (ar_fire) state_next = ST_RX_STAT_R;
            end
            ST_RX_STAT_R: begin
                RREADY = 1'b1;
                if (r_fire) state_next = RDATA[RXV_BIT] ? ST_RX_AR : ST_RX_STAT_AR;
            end
            ST_RX_AR: begin
                ARVALID = 1'b1;
                ARADDR  = RX_ADDR;
                if (ar_fire) state_next = ST_RX_R;
            end
            ST_RX_R: begin
                RREADY = 1'b1;
                if (r_fire) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= ST_IDLE;
            pending_reg <= 1'b0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            in_done_reg <= 1'b0;
            in_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            in_done_reg <= 1'b0;
            if (rx_data_fire) begin
                in_data_reg <= RDATA[DATA_W-1:0];
                in_done_reg <= 1'b1;
                pending_reg <= 1'b0;
            end else if (IN_VALID && IN_READY) begin
                pending_reg <= 1'b1;
            end
            // AW and W complete independently; the flags live only inside TX_AW.
            if (state_next != ST_TX_AW) begin
                aw_done_reg <= 1'b0;
                w_done_reg  <= 1'b0;
            end else begin
                if (aw_fire) aw_done_reg <= 1'b1;
                if (w_fire)  w_done_reg  <= 1'b1;
            end
        end
    end

    assign resp_fire[ERR_R_IDX] = r_fire;
    assign resp_fire[ERR_B_IDX] = b_fire;
    assign resp_val[ERR_R_IDX]  = RRESP;
    assign resp_val[ERR_B_IDX]  = BRESP;

    for (genvar gi = 0; gi < 2; gi++) begin : g_err_set
        assign err_set[gi] = resp_fire[gi] && (resp_val[gi] != RESP_OKAY);
    end

    // A new error in the same cycle as ERR_CLR survives the clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_reg <= '0;
        end else begin
            err_reg <= err_set | (err_reg & ~{2{ERR_CLR}});
        end
    end

    assign OUT_READY = !fifo_full;
    assign IN_READY  = !pending_reg;
    assign IN_DONE   = in_done_reg;
    assign IN_DATA   = in_data_reg;
    assign ERR       = err_reg;
    assign TX_EMPTY  = fifo_empty &&
                       !(state_reg inside {ST_TX_STAT_AR, ST_TX_STAT_R, ST_TX_AW, ST_TX_B});

endmodule

// File: tb/tb_core_io_axil.sv
// Self-checking bench for core_io_axil: an AXI4-Lite UART-Lite slave model
// plus table, hand-written and randomized sequences checked against queues.
module tb_core_io_axil;
    import core_io_pkg::*;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam logic [AW-1:0] STAT = 4'h8;
    localparam logic [AW-1:0] TXA  = 4'h4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          OUT_VALID = 1'b0;
    logic [DW-1:0] OUT_DATA = '0;
    logic          OUT_READY;
    logic          IN_VALID = 1'b0;
    logic          IN_READY, IN_DONE;
    logic [DW-1:0] IN_DATA;
    logic          TX_EMPTY;
    logic [1:0]    ERR;
    logic          ERR_CLR = 1'b0;
    logic [AW-1:0] ARADDR, AWADDR;
    logic          ARVALID, ARREADY, RVALID, RREADY;
    logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic [31:0]   RDATA, WDATA;
    logic [1:0]    RRESP, BRESP;
    logic [3:0]    WSTRB;

    always #5 CLK = ~CLK;

    core_io_axil dut (
        .CLK(CLK), .RST(RST),
        .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_READY(OUT_READY),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DONE(IN_DONE), .IN_DATA(IN_DATA),
        .TX_EMPTY(TX_EMPTY), .ERR(ERR), .ERR_CLR(ERR_CLR),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    // ---------------- slave model configuration (written by the bench only)
    int         txf_until = 0;   // status reads with index < txf_until report TX full
    int         rxv_from  = 0;   // status reads with index >= rxv_from report RX valid
    logic [7:0] rx_byte   = 8'h00;
    int         aw_delay  = 0;
    logic [1:0] bresp_val = 2'b00;
    logic [1:0] rresp_val = 2'b00;
    logic       r_stall   = 1'b0;

    // ---------------- slave model state and logs (written by the slave only)
    logic          r_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, last_txf = 1'b0;
    logic [AW-1:0] r_addr = '0, aw_addr_q = '0;
    logic [31:0]   w_data_q = '0;
    logic [3:0]    w_strb_q = '0;
    int            aw_wait = 0;
    int            stat_reads = 0, aw_count = 0, aw_bad = 0, wr_bad = 0;
    int            awv_cycles = 0, wv_cycles = 0;
    int            ev_q[$];          // AR address per AR handshake, 100 per AW handshake
    logic [31:0]   wr_log[$];        // WDATA of every completed write

    assign ARREADY = !r_pend;
    assign RVALID  = r_pend && !r_stall;
    assign RRESP   = rresp_val;
    assign RDATA   = (r_addr == STAT) ?
                     {28'b0, (stat_reads < txf_until), 2'b00, (stat_reads >= rxv_from)} :
                     {24'b0, rx_byte};
    assign AWREADY = (aw_wait >= aw_delay) && !aw_got;
    assign WREADY  = !w_got;
    assign BVALID  = b_pend;
    assign BRESP   = bresp_val;

    always @(posedge CLK) begin
        if (RST) begin
            r_pend  <= 1'b0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            b_pend  <= 1'b0;
            aw_wait <= 0;
        end else begin
            if (ARVALID && ARREADY) begin
                r_pend <= 1'b1;
                r_addr <= ARADDR;
                ev_q.push_back(int'(ARADDR));
            end
            if (RVALID && RREADY) begin
                r_pend <= 1'b0;
                if (r_addr == STAT) begin
                    stat_reads <= stat_reads + 1;
                    last_txf   <= RDATA[3];
                end
            end
            if (AWVALID) awv_cycles <= awv_cycles + 1;
            if (WVALID)  wv_cycles  <= wv_cycles + 1;
            if (AWVALID && !AWREADY) aw_wait <= aw_wait + 1;
            if (AWVALID && AWREADY) begin
                aw_got    <= 1'b1;
                aw_addr_q <= AWADDR;
                aw_wait   <= 0;
                aw_count  <= aw_count + 1;
                ev_q.push_back(100);
                if (last_txf) aw_bad <= aw_bad + 1;
            end
            if (WVALID && WREADY) begin
                w_got    <= 1'b1;
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end
            if (aw_got && w_got && !b_pend) b_pend <= 1'b1;
            if (BVALID && BREADY) begin
                b_pend <= 1'b0;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                wr_log.push_back(w_data_q);
                if (aw_addr_q != TXA || w_strb_q != 4'b0001 || w_data_q[31:8] != 24'h0)
                    wr_bad <= wr_bad + 1;
            end
        end
    end

    // ---------------- checking helpers
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " axi_valids"}, {ARVALID, RREADY, AWVALID, WVALID, BREADY}, 0);
        check({tag, " addrs"}, {ARADDR, AWADDR}, 0);
        check({tag, " wdata"}, WDATA, 0);
        check({tag, " wstrb"}, WSTRB, 0);
        check({tag, " in_done"}, IN_DONE, 0);
        check({tag, " in_data"}, IN_DATA, 0);
        check({tag, " err"}, ERR, 0);
        check({tag, " tx_empty"}, TX_EMPTY, 1);
        check({tag, " ready"}, {OUT_READY, IN_READY}, 2'b11);
    endtask

    task automatic push_out(input logic [7:0] b);
        int n = 0;
        OUT_VALID = 1'b1;
        OUT_DATA  = b;
        while (!OUT_READY && n < 2000) begin @(negedge CLK); n++; end
        check("out_accept", OUT_READY, 1);
        @(negedge CLK);
        OUT_VALID = 1'b0;
    endtask

    task automatic do_in(output logic [7:0] d);
        int n = 0;
        IN_VALID = 1'b1;
        while (!IN_READY && n < 2000) begin @(negedge CLK); n++; end
        @(negedge CLK);
        IN_VALID = 1'b0;
        n = 0;
        while (!IN_DONE && n < 2000) begin @(negedge CLK); n++; end
        check("in_done_seen", IN_DONE, 1);
        d = IN_DATA;
    endtask

    task automatic wait_tx_empty();
        int n = 0;
        while (!TX_EMPTY && n < 3000) begin @(negedge CLK); n++; end
        check("tx_drained", TX_EMPTY, 1);
    endtask

    task automatic pulse_err_clr();
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
    endtask

    typedef struct {
        logic [7:0] out_b;
        logic [7:0] rx_b;
        int         txf_n;
        int         rxv_n;
        int         aw_dly;
        logic [1:0] bresp;
        logic [1:0] rresp;
        int         exp_stat;
        logic [1:0] exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] exp_q[$];
        int base_ev, base_wr, base_st, base_aw, base_awv, base_wv, base_bad, dones;

        vecs[0] = '{8'h41, 8'h5A, 0, 0, 0, 2'b00, 2'b00, 2, 2'b00};
        vecs[1] = '{8'h10, 8'hC3, 0, 3, 0, 2'b00, 2'b00, 5, 2'b00};
        vecs[2] = '{8'h7E, 8'h01, 2, 1, 2, 2'b00, 2'b00, 5, 2'b00};
        vecs[3] = '{8'hFF, 8'h80, 0, 0, 1, 2'b10, 2'b00, 2, 2'b10};
        vecs[4] = '{8'h00, 8'hFF, 1, 0, 0, 2'b00, 2'b01, 3, 2'b01};
        vecs[5] = '{8'hA5, 8'h3C, 3, 2, 3, 2'b11, 2'b10, 7, 2'b11};

        // Reset state
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RST = 1'b0;
        @(negedge CLK);

        // Single echo: out 0x41 then in, program order 8,(AW),8,0
        base_ev = ev_q.size();
        base_wr = wr_log.size();
        rx_byte = 8'h5A;
        push_out(8'h41);
        do_in(d);
        check("echo in_data", d, 8'h5A);
        check("echo in_ready_at_done", IN_READY, 1);
        @(negedge CLK);
        check("echo in_done_pulse", IN_DONE, 0);
        wait_tx_empty();
        check("echo ev_count", ev_q.size() - base_ev, 4);
        if (ev_q.size() - base_ev == 4) begin
            check("echo ev0", ev_q[base_ev], 8);
            check("echo ev1", ev_q[base_ev+1], 100);
            check("echo ev2", ev_q[base_ev+2], 8);
            check("echo ev3", ev_q[base_ev+3], 0);
        end
        check("echo wr_count", wr_log.size() - base_wr, 1);
        if (wr_log.size() > base_wr) check("echo wdata", wr_log[base_wr], 32'h41);
        check("echo wr_fields", wr_bad, 0);

        // TX full backpressure: status reports full for 20 polls
        base_wr = wr_log.size();
        base_st = stat_reads;
        base_bad = aw_bad;
        txf_until = stat_reads + 20;
        for (int i = 0; i < 4; i++) push_out(8'h10 + 8'(i));
        check("txfull out_ready_low", OUT_READY, 0);
        push_out(8'h14);
        push_out(8'h15);
        wait_tx_empty();
        check("txfull wr_count", wr_log.size() - base_wr, 6);
        for (int i = 0; i < 6; i++)
            if (base_wr + i < wr_log.size())
                check($sformatf("txfull byte%0d", i), wr_log[base_wr+i], 32'(8'h10 + 8'(i)));
        check("txfull aw_while_full", aw_bad - base_bad, 0);
        check("txfull stat_reads", stat_reads - base_st, 26);

        // Independent AW/W handshakes
        aw_delay = 3;
        base_aw  = aw_count;
        base_awv = awv_cycles;
        base_wv  = wv_cycles;
        push_out(8'h99);
        wait_tx_empty();
        check("awdly awvalid_cycles", awv_cycles - base_awv, 4);
        check("awdly wvalid_cycles", wv_cycles - base_wv, 1);
        check("awdly writes", aw_count - base_aw, 1);
        aw_delay = 0;

        // Error flags: BRESP error is sticky, FIFO still pops, ERR_CLR clears
        base_wr = wr_log.size();
        bresp_val = 2'b10;
        push_out(8'h5E);
        wait_tx_empty();
        bresp_val = 2'b00;
        check("err popped", wr_log.size() - base_wr, 1);
        check("err set", ERR, 2'b10);
        repeat (5) @(negedge CLK);
        check("err sticky", ERR, 2'b10);
        pulse_err_clr();
        check("err cleared", ERR, 2'b00);

        // Table-driven out/in transactions
        foreach (vecs[i]) begin
            pulse_err_clr();
            check($sformatf("vec%0d err_pre", i), ERR, 2'b00);
            base_wr   = wr_log.size();
            base_st   = stat_reads;
            aw_delay  = vecs[i].aw_dly;
            bresp_val = vecs[i].bresp;
            rresp_val = vecs[i].rresp;
            txf_until = stat_reads + vecs[i].txf_n;
            push_out(vecs[i].out_b);
            wait_tx_empty();
            rxv_from = stat_reads + vecs[i].rxv_n;
            rx_byte  = vecs[i].rx_b;
            do_in(d);
            check($sformatf("vec%0d in_data", i), d, vecs[i].rx_b);
            check($sformatf("vec%0d wdata", i),
                  (wr_log.size() > base_wr) ? wr_log[base_wr] : 32'hDEAD_BEEF,
                  32'(vecs[i].out_b));
            check($sformatf("vec%0d stat_reads", i), stat_reads - base_st, vecs[i].exp_stat);
            check($sformatf("vec%0d err", i), ERR, vecs[i].exp_err);
        end
        bresp_val = 2'b00;
        rresp_val = 2'b00;
        aw_delay  = 0;
        pulse_err_clr();

        // Randomized bursts against a queue model
        for (int it = 0; it < 12; it++) begin
            int k, tn, rn;
            logic [7:0] rb;
            k  = $urandom_range(1, 3);
            tn = $urandom_range(0, 2);
            rn = $urandom_range(0, 3);
            rb = 8'($urandom);
            aw_delay  = $urandom_range(0, 2);
            base_wr   = wr_log.size();
            base_st   = stat_reads;
            txf_until = stat_reads + tn;
            exp_q.delete();
            for (int j = 0; j < k; j++) begin
                logic [7:0] b;
                b = 8'($urandom);
                exp_q.push_back(b);
                push_out(b);
            end
            wait_tx_empty();
            check($sformatf("rand%0d wr_count", it), wr_log.size() - base_wr, k);
            for (int j = 0; j < k; j++)
                if (base_wr + j < wr_log.size())
                    check($sformatf("rand%0d byte%0d", it, j), wr_log[base_wr+j], 32'(exp_q[j]));
            check($sformatf("rand%0d tx_stat", it), stat_reads - base_st, tn + k);
            base_st  = stat_reads;
            rxv_from = stat_reads + rn;
            rx_byte  = rb;
            do_in(d);
            check($sformatf("rand%0d in_data", it), d, rb);
            check($sformatf("rand%0d rx_stat", it), stat_reads - base_st, rn + 1);
        end
        aw_delay = 0;
        check("rand wr_fields", wr_bad, 0);
        check("rand err", ERR, 2'b00);

        // Reset mid-op: RX data read stalled, two bytes queued behind it
        begin
            int n = 0;
            r_stall  = 1'b1;
            rxv_from = stat_reads;
            IN_VALID = 1'b1;
            @(negedge CLK);
            IN_VALID = 1'b0;
            while (!(RREADY && ev_q.size() > 0 && ev_q[$] == 0) && n < 200) begin
                @(negedge CLK); n++;
            end
            check("rstmid in_rx_r", RREADY, 1);
            push_out(8'h11);
            push_out(8'h22);
            check("rstmid queued", TX_EMPTY, 0);
            RST = 1'b1;
            @(negedge CLK);
            check_reset_outputs("rstmid");
            RST = 1'b0;
            r_stall = 1'b0;
            base_ev = ev_q.size();
            base_wr = wr_log.size();
            dones = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge CLK);
                if (IN_DONE) dones++;
            end
            check("rstmid no_in_done", dones, 0);
            check("rstmid no_ar", ev_q.size() - base_ev, 0);
            check("rstmid no_write", wr_log.size() - base_wr, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
